// File: rtl/demux16_pkg.sv
// Shared types and constants for the 1-to-16 serial demultiplexer/deserializer.
package demux16_pkg;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned WIDTH = 2 ** SEL_W;

    localparam logic [WIDTH-1:0] RESET_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/demux16_sel_cnt.sv
// SEL_W-bit capture index counter: clear has priority over increment, and a
// terminal-count flag marks the last bit position of the word.
module demux16_sel_cnt
    import demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [SEL_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + SEL_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == SEL_W'(WIDTH - 1));

endmodule

// File: rtl/demux16_deser.sv
// Serial-to-16-bit deserializer, LSB first, with a one-cycle out_valid pulse.
// Optional direct bit-write port on data_out is enabled by DEMUX16_DIRECT_WR_EN.
module demux16_deser
    import demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic             wr_bit,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid
);

    state_e           state_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] shift_buf_q;
    logic [WIDTH-1:0] shift_buf_d;

    logic             bit_fire;
    logic             word_done;
    logic             sel_tc;

    assign bit_fire  = (state_q == SHIFT) && din_valid;
    assign word_done = bit_fire && sel_tc;

    demux16_sel_cnt u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bit_fire && !sel_tc),
        .clr_i (word_done || ((state_q == IDLE) && start)),
        .cnt_o (sel),
        .tc_o  (sel_tc)
    );

    // NOTE: default first so every path assigns shift_buf_d and no latch is inferred;
    // blocking assignments are correct here because this block is purely combinational.
    always_comb begin
        shift_buf_d = shift_buf_q;
        if (bit_fire) begin
            shift_buf_d[sel] = din;
        end
    end

    // NOTE: the capture buffer is reset explicitly; it is a flop vector, not a RAM,
    // and a reset mid-capture must leave no stale partial word behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= RESET_WORD;
            shift_buf_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            shift_buf_q <= shift_buf_d;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A completing capture overrides a same-edge direct write in full.
            if (word_done) begin
                data_out_q <= shift_buf_d;
            end
`ifdef DEMUX16_DIRECT_WR_EN
            else if (wr_en) begin
                data_out_q[wr_sel] <= wr_bit;
            end
`endif
        end
    end

`ifndef DEMUX16_DIRECT_WR_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_sel, wr_bit};
`endif

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_demux16_deser.sv
// Scoreboard bench for demux16_deser: expected words are queued at stimulus time
// and a negedge monitor compares them whenever out_valid is presented.
module tb_demux16_deser;
    import demux16_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             din;
    logic             din_valid;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic             wr_bit;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    demux16_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_bit    (wr_bit),
        .sel       (sel),
        .busy      (busy),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(data_out), 32'hdead_beef);
            end else begin
                check("scoreboard_word", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps,
                             input bit extra_start, input bit wr_last);
        exp_q.push_back(w);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            if (gaps) begin
                din_valid = 1'b0;
                din       = ~w[i];
                if (extra_start && i == 8) start = 1'b1;
                step();
                start = 1'b0;
                check("sel_hold_in_gap", 32'(sel), 32'(i));
                check("busy_in_gap", 32'(busy), 32'd1);
            end
            check("sel_index", 32'(sel), 32'(i));
            din       = w[i];
            din_valid = 1'b1;
            if (wr_last && i == WIDTH - 1) begin
                wr_en  = 1'b1;
                wr_sel = 4'hF;
                wr_bit = 1'b1;
            end
            step();
            din_valid = 1'b0;
            wr_en     = 1'b0;
        end
        check("out_valid_on_last_edge", 32'(out_valid), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("sel_cleared_at_done", 32'(sel), 32'd0);
        step();
        check("out_valid_one_cycle", 32'(out_valid), 32'd0);
        check("busy_idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] partial;
        rst_n     = 1'b0;
        start     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = '0;
        wr_bit    = 1'b0;

        #12;
        check("reset_data_out", 32'(data_out), 32'h0000);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        send_word(16'h3f0a, 1'b0, 1'b0, 1'b0);
        check("hold_after_b2b", 32'(data_out), 32'h3f0a);

        send_word(16'h3f0a, 1'b1, 1'b1, 1'b0);
        check("hold_after_gaps", 32'(data_out), 32'h3f0a);

        // Partial capture of 16'hA5C3 aborted by reset after 7 bits.
        partial = 16'hA5C3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din       = partial[i];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        check("partial_sel", 32'(sel), 32'd7);
        rst_n = 1'b0;
        #2;
        check("midreset_data_out", 32'(data_out), 32'h0000);
        check("midreset_sel", 32'(sel), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        send_word(16'hA5C3, 1'b0, 1'b0, 1'b0);
        check("hold_after_a5c3", 32'(data_out), 32'hA5C3);

`ifdef DEMUX16_DIRECT_WR_EN
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        wr_en  = 1'b1;
        wr_sel = 4'hF;
        wr_bit = 1'b1;
        step();
        wr_en = 1'b0;
        check("direct_wr_data_out", 32'(data_out), 32'h8000);
        check("direct_wr_no_valid", 32'(out_valid), 32'd0);
        check("direct_wr_busy", 32'(busy), 32'd0);
        check("direct_wr_sel", 32'(sel), 32'd0);
        wr_en  = 1'b1;
        wr_sel = 4'h2;
        wr_bit = 1'b1;
        step();
        wr_en = 1'b0;
        check("direct_wr_bit2", 32'(data_out), 32'h8004);
        check("direct_wr_bit2_no_valid", 32'(out_valid), 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            wr_en  = 1'b1;
            wr_sel = SEL_W'(k * 5);
            wr_bit = ~partial[k * 5];
            step();
            wr_en = 1'b0;
            check("ignored_wr_data_out", 32'(data_out), 32'hA5C3);
            check("ignored_wr_no_valid", 32'(out_valid), 32'd0);
        end
`endif

        send_word(16'h0001, 1'b0, 1'b0, 1'b1);
        check("completion_beats_wr", 32'(data_out), 32'h0001);

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
